// File: rtl/pt_check_pkg.sv
// Shared constants and helpers for the ARC4 crack datapath: plaintext
// layout, printable range and the plaintext checker state encoding.
package pt_check_pkg;

  localparam logic [7:0] PT_LEN_ADDR = 8'd0;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    SCAN = 2'd2
  } pt_state_e;

  // Unsigned inclusive range test; 8'h7F and all high-bit bytes fall outside.
  function automatic logic is_printable(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_check.sv
// Plaintext validator: scans a length-prefixed message (byte 0 = length)
// one byte per cycle against a synchronous-read memory and reports whether
// every message byte is printable, exiting early on the first bad byte.
module pt_check
  import pt_check_pkg::*;
#(
  parameter logic [7:0] LO = PRINT_LO,
  parameter logic [7:0] HI = PRINT_HI
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       ok,
  output logic [7:0] bad_idx,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
);

  pt_state_e  state, state_n;
  logic [7:0] len, len_n;
  logic [7:0] idx, idx_n;
  logic       ok_n;
  logic [7:0] bad_idx_n;

  // The checker is idle exactly when it can accept a new request.
  assign rdy = (state == IDLE);

  // State and result registers; reset discards any partial scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len     <= 8'd0;
      idx     <= 8'd0;
      ok      <= 1'b0;
      bad_idx <= 8'd0;
    end else begin
      state   <= state_n;
      len     <= len_n;
      idx     <= idx_n;
      ok      <= ok_n;
      bad_idx <= bad_idx_n;
    end
  end

  // Next-state and address generation. LEN takes two cycles (idx 0 then 1):
  // the first issues address 0, the second issues address 1 while the length
  // byte arrives. In SCAN the address runs one ahead of idx so data for byte
  // idx is on pt_rddata in the cycle idx is checked; the one-past-the-end
  // read is speculative and its data is never looked at.
  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    ok_n      = ok;
    bad_idx_n = bad_idx;
    pt_addr   = PT_LEN_ADDR;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = LEN;
          idx_n   = 8'd0;
          len_n   = 8'd0;
        end
      end

      LEN: begin
        pt_addr = idx;
        if (idx == 8'd0) begin
          idx_n = 8'd1;
        end else begin
          len_n = pt_rddata;
          if (pt_rddata == 8'd0) begin
            ok_n      = 1'b1;
            bad_idx_n = 8'd0;
            state_n   = IDLE;
          end else begin
            state_n = SCAN;
          end
        end
      end

      SCAN: begin
        pt_addr = (idx == 8'hFF) ? 8'hFF : idx + 8'd1;
        if (!is_printable(pt_rddata, LO, HI)) begin
          ok_n      = 1'b0;
          bad_idx_n = idx;
          state_n   = IDLE;
        end else if (idx == len) begin
          ok_n      = 1'b1;
          bad_idx_n = 8'd0;
          state_n   = IDLE;
        end else begin
          idx_n = idx + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pt_check.sv
// Self-checking bench for pt_check: directed scans from the test plan plus
// randomized messages, checked against a behavioural model of the scan.
module tb_pt_check;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic       ok;
  logic [7:0] bad_idx;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;

  logic [7:0] mem [256];
  logic [7:0] img [$];

  int n_total;
  int n_bad;

  pt_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .ok        (ok),
    .bad_idx   (bad_idx),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: registered address, data one cycle later.
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_total++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Copy img into memory; unused locations hold a non-printable filler.
  task automatic load_mem();
    for (int i = 0; i < 256; i++)
      mem[i] = (i < img.size()) ? img[i] : 8'h01;
  endtask

  // Reference: walk the message by its length prefix and find the first
  // byte outside 0x20..0x7E; result appears two edges after that byte's index.
  task automatic model(output logic exp_ok, output logic [7:0] exp_bad,
                       output int exp_lat);
    int l;
    l       = int'(mem[0]);
    exp_ok  = 1'b1;
    exp_bad = 8'd0;
    exp_lat = l + 2;
    for (int i = 1; i <= l; i++) begin
      if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
        exp_ok  = 1'b0;
        exp_bad = 8'(i);
        exp_lat = i + 2;
        break;
      end
    end
  endtask

  // Run one scan: pulse en, follow it to completion (bounded), then compare
  // latency, results, address sequence and result stability during the scan.
  task automatic apply_stimulus(input string tag, input bit noisy);
    logic       exp_ok;
    logic [7:0] exp_bad;
    int         exp_lat;
    logic       prev_ok;
    logic [7:0] prev_bad;
    int         lat;
    int         seq_err;
    int         hold_err;
    bit         done;
    logic [7:0] exp_addr;

    model(exp_ok, exp_bad, exp_lat);
    @(negedge clk);
    check_output({tag, ".rdy_before"}, 32'(rdy), 32'd1);
    prev_ok  = ok;
    prev_bad = bad_idx;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = noisy ? 1'($urandom) : 1'b0;
    lat      = 999;
    seq_err  = 0;
    hold_err = 0;
    done     = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (rdy) begin
        done = 1'b1;
        lat  = c;
        en   = 1'b0;
      end else begin
        exp_addr = (c >= 255) ? 8'd255 : 8'(c);
        if (pt_addr !== exp_addr) seq_err++;
        if (ok !== prev_ok || bad_idx !== prev_bad) hold_err++;
        @(posedge clk);
        #1;
        en = noisy ? 1'($urandom) : 1'b0;
      end
    end
    en = 1'b0;
    check_output({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, ".ok"}, 32'(ok), 32'(exp_ok));
    check_output({tag, ".bad_idx"}, 32'(bad_idx), 32'(exp_bad));
    check_output({tag, ".addr_seq_errors"}, 32'(seq_err), 32'd0);
    check_output({tag, ".hold_errors"}, 32'(hold_err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".rdy"}, 32'(rdy), 32'd1);
    check_output({tag, ".ok"}, 32'(ok), 32'd0);
    check_output({tag, ".bad_idx"}, 32'(bad_idx), 32'd0);
    check_output({tag, ".pt_addr"}, 32'(pt_addr), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    en      = 1'b0;
    rst_n   = 1'b0;
    img     = '{8'd0};
    load_mem();

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Directed: three printable bytes.
    img = '{8'd3, 8'h41, 8'h42, 8'h43};
    load_mem();
    apply_stimulus("abc", 1'b0);

    // Directed: 0x7F at index 3 stops the scan early.
    img = '{8'd5, 8'h68, 8'h69, 8'h7F, 8'h78, 8'h79};
    load_mem();
    apply_stimulus("del_at_3", 1'b0);

    // Directed: zero length, then range boundaries.
    img = '{8'd0};
    load_mem();
    apply_stimulus("empty", 1'b0);
    img = '{8'd2, 8'h20, 8'h7E};
    load_mem();
    apply_stimulus("bounds_ok", 1'b0);
    img = '{8'd1, 8'h1F};
    load_mem();
    apply_stimulus("below_lo", 1'b0);
    img = '{8'd1, 8'h80};
    load_mem();
    apply_stimulus("high_bit", 1'b0);

    // Directed: maximum length with spurious en pulses throughout.
    img = {};
    img.push_back(8'd255);
    for (int i = 1; i < 256; i++) img.push_back(8'h61);
    load_mem();
    apply_stimulus("len255", 1'b1);

    // Back-to-back: bad message, then a good one written while idle.
    img = '{8'd4, 8'h41, 8'h09, 8'h41, 8'h41};
    load_mem();
    apply_stimulus("b2b_bad", 1'b0);
    img = '{8'd4, 8'h41, 8'h42, 8'h43, 8'h44};
    load_mem();
    apply_stimulus("b2b_good", 1'b0);

    // Reset three edges into a scan: outputs return to reset values at once.
    img = '{8'd10, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41,
            8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    load_mem();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_values($sformatf("idle_%0d", i));
    end
    apply_stimulus("after_reset", 1'b0);

    // Randomized messages, some with non-printable bytes.
    for (int t = 0; t < 25; t++) begin
      int l;
      l   = $urandom_range(0, 30);
      img = {};
      img.push_back(8'(l));
      for (int i = 1; i <= l; i++) begin
        if ($urandom_range(0, 9) == 0)
          img.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31))
                                                     : 8'($urandom_range(127, 255)));
        else
          img.push_back(8'($urandom_range(32, 126)));
      end
      load_mem();
      apply_stimulus($sformatf("rand_%0d", t), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
